scalar_mult_msb: RTL and testbench

- Parametrised successor to the LSB-first double-and-add scalar multiplier. Computes k·P on y² = x³ + a·x + b mod p.
- Scans the scalar MSB-first, tracks the point at infinity explicitly, and handles the R == ±P special cases.
- Uses a start/busy/done handshake.
- Instantiates the existing point_doubling and point_addition engines. Sits between the key/scalar interface and the field-arithmetic engines.

---
 rtl/scalar_mult_msb.sv | 386 ++++++++++++++++++++++++++++++++++++++
 tb/tb_scalar_mult_msb.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/scalar_mult_msb.sv
// scalar_mult_msb: MSB-first double-and-add scalar multiplier k*P on
// y^2 = x^3 + a*x + b mod p, with explicit point-at-infinity tracking.
// Optional macro SCALAR_MULT_CONST_TIME_EN: every bit takes the same number
// of cycles (dummy engine passes, discarded results).
// Also holds the point_doubling / point_addition engines and their shared core.

// Shared affine point engine: lambda via Fermat inverse, bit-serial mod-mult.
// Both modes run the same micro-sequence so every pass has identical length.
module ec_point_core #(
  parameter int unsigned N      = 231,
  parameter bit          DOUBLE = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] p, a, x1, y1, x2, y2,
  output logic [N-1:0] x3, y3,
  output logic         infinity,
  output logic         result
);
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [3:0] {C_INIT, C_NUM, C_INV_SQ, C_INV_ML, C_INV_NX,
                            C_SQ, C_X3, C_Y3, C_DONE, C_MUL} cstate_t;
  typedef enum logic [1:0] {D_T, D_INV, D_LAM} dst_t;

  cstate_t       r_st, r_ret;
  dst_t          r_dst;
  logic [CW-1:0] r_cnt, r_idx;
  logic [N-1:0]  r_acc, r_ma, r_mb, r_t, r_num, r_den, r_inv, r_lam, r_x3, r_y3;
  logic          r_inf, r_res;
  logic [N-1:0]  w_e, w_addend, w_step, w_x2, w_x3n;

  function automatic logic [N-1:0] f_add(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic [N-1:0] m);
    logic [N:0] s;
    s = {1'b0, x} + {1'b0, y};
    if (s >= {1'b0, m}) s = s - {1'b0, m};
    return s[N-1:0];
  endfunction

  function automatic logic [N-1:0] f_sub(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic [N-1:0] m);
    return (x >= y) ? (x - y) : (x + (m - y));
  endfunction

  assign w_e      = p - N'(2);
  assign w_addend = r_mb[r_cnt] ? r_ma : '0;
  assign w_step   = f_add(f_add(r_acc, r_acc, p), w_addend, p);
  assign w_x2     = DOUBLE ? x1 : x2;
  assign w_x3n    = f_sub(f_sub(r_t, x1, p), w_x2, p);

  // Micro-sequencer; C_MUL is a shared N-cycle multiply returning to r_ret.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_st  <= C_INIT;
      r_res <= 1'b0;
      r_inf <= 1'b0;
      r_x3  <= '0;
      r_y3  <= '0;
    end else begin
      case (r_st)
        C_INIT: begin
          // x1^2 is computed in both modes to keep pass length mode-independent
          r_inf <= DOUBLE ? (y1 == '0) : (x1 == x2);
          r_ma <= x1; r_mb <= x1; r_acc <= '0; r_cnt <= CW'(N - 1);
          r_dst <= D_T; r_ret <= C_NUM; r_st <= C_MUL;
        end
        C_NUM: begin
          if (DOUBLE) begin
            r_num <= f_add(f_add(f_add(r_t, r_t, p), r_t, p), a, p);
            r_den <= f_add(y1, y1, p);
          end else begin
            r_num <= f_sub(y2, y1, p);
            r_den <= f_sub(x2, x1, p);
          end
          r_inv <= N'(1);
          r_idx <= CW'(N - 1);
          r_st  <= C_INV_SQ;
        end
        C_INV_SQ: begin
          r_ma <= r_inv; r_mb <= r_inv; r_acc <= '0; r_cnt <= CW'(N - 1);
          r_dst <= D_INV; r_ret <= C_INV_ML; r_st <= C_MUL;
        end
        C_INV_ML: begin
          if (w_e[r_idx]) begin
            r_ma <= r_inv; r_mb <= r_den; r_acc <= '0; r_cnt <= CW'(N - 1);
            r_dst <= D_INV; r_ret <= C_INV_NX; r_st <= C_MUL;
          end else begin
            r_st <= C_INV_NX;
          end
        end
        C_INV_NX: begin
          if (r_idx == '0) begin
            r_ma <= r_num; r_mb <= r_inv; r_acc <= '0; r_cnt <= CW'(N - 1);
            r_dst <= D_LAM; r_ret <= C_SQ; r_st <= C_MUL;
          end else begin
            r_idx <= r_idx - CW'(1);
            r_st  <= C_INV_SQ;
          end
        end
        C_SQ: begin
          r_ma <= r_lam; r_mb <= r_lam; r_acc <= '0; r_cnt <= CW'(N - 1);
          r_dst <= D_T; r_ret <= C_X3; r_st <= C_MUL;
        end
        C_X3: begin
          r_x3 <= w_x3n;
          r_ma <= r_lam; r_mb <= f_sub(x1, w_x3n, p); r_acc <= '0; r_cnt <= CW'(N - 1);
          r_dst <= D_T; r_ret <= C_Y3; r_st <= C_MUL;
        end
        C_Y3: begin
          r_y3  <= f_sub(r_t, y1, p);
          r_res <= 1'b1;
          r_st  <= C_DONE;
        end
        C_MUL: begin
          r_acc <= w_step;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == '0) begin
            case (r_dst)
              D_INV:   r_inv <= w_step;
              D_LAM:   r_lam <= w_step;
              default: r_t   <= w_step;
            endcase
            r_st <= r_ret;
          end
        end
        default: r_st <= C_DONE;
      endcase
    end
  end

  assign x3       = r_x3;
  assign y3       = r_y3;
  assign infinity = r_inf;
  assign result   = r_res;
endmodule

// Point doubling engine: 2*(x1,y1); infinity when y1 == 0.
module point_doubling #(
  parameter int unsigned N = 231
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] p, a, x1, y1,
  output logic [N-1:0] x3, y3,
  output logic         infinity,
  output logic         result
);
  ec_point_core #(.N(N), .DOUBLE(1'b1)) u_core (
    .clk(clk), .reset(reset), .p(p), .a(a), .x1(x1), .y1(y1), .x2(x1), .y2(y1),
    .x3(x3), .y3(y3), .infinity(infinity), .result(result));
endmodule

// Point addition engine: (x1,y1)+(x2,y2); infinity when x1 == x2.
module point_addition #(
  parameter int unsigned N = 231
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] p, a, x1, y1, x2, y2,
  output logic [N-1:0] x3, y3,
  output logic         infinity,
  output logic         result
);
  ec_point_core #(.N(N), .DOUBLE(1'b0)) u_core (
    .clk(clk), .reset(reset), .p(p), .a(a), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
    .x3(x3), .y3(y3), .infinity(infinity), .result(result));
endmodule

module scalar_mult_msb #(
  parameter int unsigned N      = 231,
  parameter int unsigned K_BITS = 231
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [N-1:0]      p,
  input  logic [N-1:0]      a,
  input  logic [K_BITS-1:0] k,
  input  logic [N-1:0]      x1,
  input  logic [N-1:0]      y1,
  output logic              busy,
  output logic              done,
  output logic [N-1:0]      x3,
  output logic [N-1:0]      y3,
  output logic              infinity
);
  localparam int unsigned IW = (K_BITS > 1) ? $clog2(K_BITS) : 1;

  typedef enum logic [3:0] {S_IDLE, S_SCAN, S_DBL_START, S_DBL_WAIT, S_BIT,
                            S_DBL2_START, S_DBL2_WAIT, S_ADD_START, S_ADD_WAIT,
                            S_DONE} state_t;

  state_t            r_state;
  logic [K_BITS-1:0] r_k;
  logic [IW-1:0]     r_i;
  logic [N-1:0]      r_px, r_py, r_rx, r_ry, r_ox1, r_oy1, r_ox2, r_oy2, r_x3, r_y3;
  logic              r_rinf, r_dummy, r_busy, r_done, r_inf;

  logic              w_kbit, w_eqx, w_eqy, w_last, w_dbl_rst, w_add_rst;
  state_t            w_next_state;
  logic [IW-1:0]     w_next_i;
  logic [N-1:0]      w_dbl_x3, w_dbl_y3, w_add_x3, w_add_y3;
  logic              w_dbl_inf, w_dbl_res, w_add_inf, w_add_res;

  assign w_kbit       = r_k[r_i];
  assign w_eqx        = (r_rx == r_px);
  assign w_eqy        = (r_ry == r_py);
  assign w_last       = (r_i == '0);
  assign w_next_state = w_last ? S_DONE : S_SCAN;
  assign w_next_i     = w_last ? r_i : (r_i - IW'(1));
  // Engines run only in their WAIT states; START is their one-cycle reset.
  assign w_dbl_rst    = reset | !((r_state == S_DBL_WAIT) || (r_state == S_DBL2_WAIT));
  assign w_add_rst    = reset | (r_state != S_ADD_WAIT);

`ifdef SCALAR_MULT_CONST_TIME_EN
  typedef enum logic [2:0] {A_NONE, A_SETP, A_INF, A_ADD, A_DBL} act_t;
  act_t r_act;
  act_t w_act;
  assign w_act = !w_kbit ? A_NONE :
                 r_rinf ? A_SETP :
                 (w_eqx && w_eqy) ? A_DBL :
                 w_eqx ? A_INF : A_ADD;
`endif

  point_doubling #(.N(N)) u_dbl (
    .clk(clk), .reset(w_dbl_rst), .p(p), .a(a), .x1(r_ox1), .y1(r_oy1),
    .x3(w_dbl_x3), .y3(w_dbl_y3), .infinity(w_dbl_inf), .result(w_dbl_res));

  point_addition #(.N(N)) u_add (
    .clk(clk), .reset(w_add_rst), .p(p), .a(a), .x1(r_ox1), .y1(r_oy1),
    .x2(r_ox2), .y2(r_oy2),
    .x3(w_add_x3), .y3(w_add_y3), .infinity(w_add_inf), .result(w_add_res));

  // Control FSM: scan k MSB-first, double then conditionally add per bit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_x3    <= '0;
      r_y3    <= '0;
      r_inf   <= 1'b0;
      r_i     <= '0;
      r_rinf  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_k     <= k;
            r_px    <= x1;
            r_py    <= y1;
            r_rinf  <= 1'b1;
            r_i     <= IW'(K_BITS - 1);
            r_busy  <= 1'b1;
            r_state <= S_SCAN;
          end
        end
        S_SCAN: begin
`ifdef SCALAR_MULT_CONST_TIME_EN
          // Doubling O is replaced by a discarded pass on P
          r_ox1   <= r_rinf ? r_px : r_rx;
          r_oy1   <= r_rinf ? r_py : r_ry;
          r_dummy <= r_rinf;
          r_state <= S_DBL_START;
`else
          r_dummy <= 1'b0;
          if (r_rinf) begin
            r_state <= S_BIT;
          end else begin
            r_ox1   <= r_rx;
            r_oy1   <= r_ry;
            r_state <= S_DBL_START;
          end
`endif
        end
        S_DBL_START: r_state <= S_DBL_WAIT;
        S_DBL_WAIT: begin
          if (w_dbl_res) begin
            if (!r_dummy) begin
              r_rx   <= w_dbl_x3;
              r_ry   <= w_dbl_y3;
              r_rinf <= w_dbl_inf;
            end
            r_state <= S_BIT;
          end
        end
        S_BIT: begin
`ifdef SCALAR_MULT_CONST_TIME_EN
          // Every bit costs one engine pass; the real effect is applied in ADD_WAIT
          r_act <= w_act;
          if (w_act == A_DBL) begin
            r_ox1   <= r_rx;
            r_oy1   <= r_ry;
            r_state <= S_DBL2_START;
          end else begin
            r_ox1   <= r_rinf ? r_px : r_rx;
            r_oy1   <= r_rinf ? r_py : r_ry;
            r_ox2   <= r_px;
            r_oy2   <= r_py;
            r_state <= S_ADD_START;
          end
`else
          if (!w_kbit) begin
            r_state <= w_next_state;
            r_i     <= w_next_i;
          end else if (r_rinf) begin
            r_rx    <= r_px;
            r_ry    <= r_py;
            r_rinf  <= 1'b0;
            r_state <= w_next_state;
            r_i     <= w_next_i;
          end else if (w_eqx && w_eqy) begin
            r_ox1   <= r_rx;
            r_oy1   <= r_ry;
            r_state <= S_DBL2_START;
          end else if (w_eqx) begin
            r_rinf  <= 1'b1;
            r_state <= w_next_state;
            r_i     <= w_next_i;
          end else begin
            r_ox1   <= r_rx;
            r_oy1   <= r_ry;
            r_ox2   <= r_px;
            r_oy2   <= r_py;
            r_state <= S_ADD_START;
          end
`endif
        end
        S_DBL2_START: r_state <= S_DBL2_WAIT;
        S_DBL2_WAIT: begin
          if (w_dbl_res) begin
            r_rx    <= w_dbl_x3;
            r_ry    <= w_dbl_y3;
            r_rinf  <= w_dbl_inf;
            r_state <= w_next_state;
            r_i     <= w_next_i;
          end
        end
        S_ADD_START: r_state <= S_ADD_WAIT;
        S_ADD_WAIT: begin
          if (w_add_res) begin
`ifdef SCALAR_MULT_CONST_TIME_EN
            case (r_act)
              A_ADD: begin
                r_rx   <= w_add_x3;
                r_ry   <= w_add_y3;
                r_rinf <= w_add_inf;
              end
              A_SETP: begin
                r_rx   <= r_px;
                r_ry   <= r_py;
                r_rinf <= 1'b0;
              end
              A_INF:   r_rinf <= 1'b1;
              default: ;
            endcase
`else
            r_rx   <= w_add_x3;
            r_ry   <= w_add_y3;
            r_rinf <= w_add_inf;
`endif
            r_state <= w_next_state;
            r_i     <= w_next_i;
          end
        end
        S_DONE: begin
          r_x3    <= r_rinf ? '0 : r_rx;
          r_y3    <= r_rinf ? '0 : r_ry;
          r_inf   <= r_rinf;
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign x3       = r_x3;
  assign y3       = r_y3;
  assign infinity = r_inf;
endmodule

// File: tb/tb_scalar_mult_msb.sv
// Bench for scalar_mult_msb on y^2 = x^3 + 2x + 2 mod 17, P = (5,1), order 19.
module tb_scalar_mult_msb;
  localparam int unsigned N   = 8;
  localparam int unsigned KB  = 5;
  localparam int          TMO = 8000;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic       inf;
    logic [4:0] k;
  } exp_t;

  logic          clk = 1'b0;
  logic          reset, start;
  logic [N-1:0]  s_p, s_a, s_x1, s_y1, o_x3, o_y3;
  logic [KB-1:0] s_k;
  logic          o_busy, o_done, o_inf;

  exp_t exp_q[$];
  exp_t m_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   t_start = 0;
  int   lat = 0;
  int   lat1 = 0;
  int   lat16 = 0;
  int   lat31 = 0;

  scalar_mult_msb #(.N(N), .K_BITS(KB)) dut (
    .clk(clk), .reset(reset), .start(start), .p(s_p), .a(s_a), .k(s_k),
    .x1(s_x1), .y1(s_y1), .busy(o_busy), .done(o_done), .x3(o_x3), .y3(o_y3),
    .infinity(o_inf));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    n_vec++;
    if (act != req) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest pending expectation
  always @(negedge clk) begin
    if (!reset && o_done) begin
      chk("busy_low_with_done", int'(o_busy), 0);
      chk("done_has_pending_start", int'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) begin
        m_e = exp_q.pop_front();
        chk($sformatf("x3 k=%0d", m_e.k), int'(o_x3), int'(m_e.x));
        chk($sformatf("y3 k=%0d", m_e.k), int'(o_y3), int'(m_e.y));
        chk($sformatf("inf k=%0d", m_e.k), int'(o_inf), int'(m_e.inf));
      end
    end
  end

  task automatic do_start(input logic [KB-1:0] kv);
    @(negedge clk);
    s_k   = kv;
    start = 1'b1;
    @(posedge clk);
    #1;
    t_start = cyc;
    start   = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (n < TMO) begin
      @(negedge clk);
      if (o_done) break;
      n++;
    end
    chk({name, " done_seen"}, int'(o_done), 1);
    lat = cyc - t_start;
  endtask

  task automatic run(input logic [KB-1:0] kv, input int ex, input int ey, input int ei);
    exp_t e;
    e.x   = 8'(ex);
    e.y   = 8'(ey);
    e.inf = ei[0];
    e.k   = kv;
    exp_q.push_back(e);
    do_start(kv);
    wait_done($sformatf("k=%0d", kv));
  endtask

  initial begin
    exp_t e;
    int   n;
    reset = 1'b1;
    start = 1'b0;
    s_p   = 8'd17;
    s_a   = 8'd2;
    s_x1  = 8'd5;
    s_y1  = 8'd1;
    s_k   = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset busy", int'(o_busy), 0);
    chk("reset done", int'(o_done), 0);
    chk("reset x3", int'(o_x3), 0);
    chk("reset y3", int'(o_y3), 0);
    chk("reset inf", int'(o_inf), 0);
    reset = 1'b0;

    run(5'd1, 5, 1, 0);
`ifndef SCALAR_MULT_CONST_TIME_EN
    chk("latency k=1", lat, 11);
`endif
    run(5'd2, 6, 3, 0);
    run(5'd9, 7, 6, 0);
    run(5'd18, 5, 16, 0);
    run(5'd19, 0, 0, 1);
    run(5'd0, 0, 0, 1);
`ifndef SCALAR_MULT_CONST_TIME_EN
    chk("latency k=0", lat, 11);
`endif
    run(5'd20, 5, 1, 0);
    run(5'd21, 6, 3, 0);

    // start re-pulsed while busy must not disturb k=13
    e.x = 8'd16; e.y = 8'd4; e.inf = 1'b0; e.k = 5'd13;
    exp_q.push_back(e);
    do_start(5'd13);
    repeat (5) @(negedge clk);
    chk("busy mid-op", int'(o_busy), 1);
    s_k   = 5'd3;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("k=13 restart ignored");
    run(5'd3, 10, 6, 0);
    repeat (10) @(negedge clk);
    chk("hold x3", int'(o_x3), 10);
    chk("hold y3", int'(o_y3), 6);

    // reset during the final addition of k=17, with start asserted alongside
    do_start(5'd17);
    n = 0;
    while (dut.w_add_rst && n < TMO) begin
      @(negedge clk);
      n++;
    end
    chk("reached add phase", int'(dut.w_add_rst), 0);
    repeat (20) @(negedge clk);
    reset = 1'b1;
    start = 1'b1;
    s_k   = 5'd2;
    @(negedge clk);
    chk("midrun reset busy", int'(o_busy), 0);
    chk("midrun reset done", int'(o_done), 0);
    chk("midrun reset x3", int'(o_x3), 0);
    chk("midrun reset y3", int'(o_y3), 0);
    chk("midrun reset inf", int'(o_inf), 0);
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("start under reset ignored", int'(o_busy), 0);
    run(5'd17, 6, 14, 0);

`ifdef SCALAR_MULT_CONST_TIME_EN
    run(5'd1, 5, 1, 0);
    lat1 = lat;
    run(5'd16, 10, 11, 0);
    lat16 = lat;
    run(5'd31, 0, 11, 0);
    lat31 = lat;
    chk("const-time latency k=16", lat16, lat1);
    chk("const-time latency k=31", lat31, lat1);
`endif

    repeat (5) @(negedge clk);
    chk("expectations drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
